// File: rtl/gb_timer.sv
// gb_timer -- DMG timer/divider peripheral (DIV, TIMA, TMA, TAC at FF04-FF07).
//
// A free-running 16-bit divider provides DIV (upper byte) and the TIMA clock
// taps. TIMA counts falling edges of the selected tap gated by TAC[2]. On
// overflow it is reloaded from TMA and timer_irq pulses for one clock.
//
// Ports:
//   clock      in   CPU T-cycle clock, all state on the rising edge
//   reset_n    in   asynchronous active-low reset
//   mem_addr   in   CPU bus address [15:0]
//   data_out   in   CPU write data [7:0]
//   mem_wr     in   write strobe, sampled on the rising edge
//   data_in    out  read data [7:0], combinational from mem_addr
//   timer_irq  out  registered one-clock timer interrupt request
//
// Optional feature macro: GB_TIMER_OVF_DELAY_EN
//   Defined   : after overflow TIMA reads 00 for 4 clocks (OVF), then one
//               RELOAD clock loads TMA and raises timer_irq. A TIMA write
//               during OVF cancels the reload and the irq.
//   Undefined : the overflow edge loads TMA directly and timer_irq is high
//               in the following clock.
module gb_timer (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [15:0] mem_addr,
   input  logic [7:0]  data_out,
   input  logic        mem_wr,
   output logic [7:0]  data_in,
   output logic        timer_irq
);

   localparam logic [15:0] ADDR_DIV  = 16'hFF04;
   localparam logic [15:0] ADDR_TIMA = 16'hFF05;
   localparam logic [15:0] ADDR_TMA  = 16'hFF06;
   localparam logic [15:0] ADDR_TAC  = 16'hFF07;

   logic [15:0] sys_cnt_q, sys_cnt_d;
   logic [7:0]  tima_q, tima_d;
   logic [7:0]  tma_q, tma_d;
   logic [2:0]  tac_q, tac_d;
   logic        tick_q, tick_d;
   logic        irq_q, irq_d;

`ifdef GB_TIMER_OVF_DELAY_EN
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_OVF    = 2'd1,
      ST_RELOAD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  ovf_cnt_q, ovf_cnt_d;
`endif

   logic wr_div, wr_tima, wr_tma, wr_tac;
   logic tap_bit, tick, tick_fall;

   assign wr_div  = mem_wr && (mem_addr == ADDR_DIV);
   assign wr_tima = mem_wr && (mem_addr == ADDR_TIMA);
   assign wr_tma  = mem_wr && (mem_addr == ADDR_TMA);
   assign wr_tac  = mem_wr && (mem_addr == ADDR_TAC);

   // Tap select; the tick is the tap gated by the enable, so clearing DIV,
   // changing the tap or disabling can all produce a counted falling edge.
   always_comb begin
      tap_bit = 1'b0;
      case (tac_q[1:0])
         2'b00: tap_bit = sys_cnt_q[9];
         2'b01: tap_bit = sys_cnt_q[3];
         2'b10: tap_bit = sys_cnt_q[5];
         2'b11: tap_bit = sys_cnt_q[7];
         default: tap_bit = 1'b0;
      endcase
   end

   assign tick      = tac_q[2] & tap_bit;
   assign tick_fall = tick_q & ~tick;

   // Divider and the simple register files
   always_comb begin
      sys_cnt_d = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
      tma_d     = wr_tma ? data_out : tma_q;
      tac_d     = wr_tac ? data_out[2:0] : tac_q;
      tick_d    = tick;
   end

`ifdef GB_TIMER_OVF_DELAY_EN
   // TIMA / overflow sequencer. tma_d is used for every reload so a TMA write
   // landing on the reload edge takes effect immediately.
   always_comb begin
      state_d   = state_q;
      ovf_cnt_d = ovf_cnt_q;
      tima_d    = tima_q;
      irq_d     = 1'b0;
      case (state_q)
         ST_RUN: begin
            // A CPU write beats a coincident tick edge.
            if (wr_tima) begin
               tima_d = data_out;
            end else if (tick_fall) begin
               if (tima_q == 8'hFF) begin
                  tima_d    = 8'h00;
                  ovf_cnt_d = 2'd0;
                  state_d   = ST_OVF;
               end else begin
                  tima_d = tima_q + 8'd1;
               end
            end
         end
         ST_OVF: begin
            // TIMA sits at 00; ticks are not counted until the sequence ends.
            if (wr_tima) begin
               tima_d  = data_out;
               state_d = ST_RUN;
            end else begin
               tima_d    = 8'h00;
               ovf_cnt_d = ovf_cnt_q + 2'd1;
               if (ovf_cnt_q == 2'd3) begin
                  tima_d  = tma_d;
                  irq_d   = 1'b1;
                  state_d = ST_RELOAD;
               end
            end
         end
         ST_RELOAD: begin
            // TMA wins over any TIMA write in this clock.
            tima_d  = tma_d;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end
`else
   always_comb begin
      tima_d = tima_q;
      irq_d  = 1'b0;
      if (wr_tima) begin
         tima_d = data_out;
      end else if (tick_fall) begin
         if (tima_q == 8'hFF) begin
            tima_d = tma_d;
            irq_d  = 1'b1;
         end else begin
            tima_d = tima_q + 8'd1;
         end
      end
   end
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sys_cnt_q <= 16'h0000;
         tima_q    <= 8'h00;
         tma_q     <= 8'h00;
         tac_q     <= 3'b000;
         tick_q    <= 1'b0;
         irq_q     <= 1'b0;
`ifdef GB_TIMER_OVF_DELAY_EN
         state_q   <= ST_RUN;
         ovf_cnt_q <= 2'd0;
`endif
      end else begin
         sys_cnt_q <= sys_cnt_d;
         tima_q    <= tima_d;
         tma_q     <= tma_d;
         tac_q     <= tac_d;
         tick_q    <= tick_d;
         irq_q     <= irq_d;
`ifdef GB_TIMER_OVF_DELAY_EN
         state_q   <= state_d;
         ovf_cnt_q <= ovf_cnt_d;
`endif
      end
   end

   assign timer_irq = irq_q;

   // Read mux
   always_comb begin
      data_in = 8'hFF;
      case (mem_addr)
         ADDR_DIV:  data_in = sys_cnt_q[15:8];
         ADDR_TIMA: data_in = tima_q;
         ADDR_TMA:  data_in = tma_q;
         ADDR_TAC:  data_in = {5'b11111, tac_q};
         default:   data_in = 8'hFF;
      endcase
   end

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer. Stimulus tasks each occupy exactly one clock
// and push the expected values for that clock; the monitor pops them on the
// falling edge and compares against the DUT.
module tb_gb_timer;

   logic        clock;
   logic        reset_n;
   logic [15:0] mem_addr;
   logic [7:0]  data_out;
   logic        mem_wr;
   logic [7:0]  data_in;
   logic        timer_irq;

   gb_timer dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .mem_addr  (mem_addr),
      .data_out  (data_out),
      .mem_wr    (mem_wr),
      .data_in   (data_in),
      .timer_irq (timer_irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // kind: 0 = data_in, 1 = timer_irq, 2 = irq pulse count so far
   typedef struct {
      int         kind;
      logic [7:0] exp;
      string      name;
   } chk_t;

   chk_t scb[$];
   int   chk_n    = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   irq_cnt  = 0;
   logic irq_prev = 1'b0;

   always @(negedge clock) begin
      for (int i = 0; i < chk_n; i++) begin
         if (scb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: expected entries missing");
         end else begin
            chk_t e;
            logic [7:0] act;
            e = scb.pop_front();
            case (e.kind)
               0:       act = data_in;
               1:       act = {7'd0, timer_irq};
               default: act = irq_cnt[7:0];
            endcase
            n_checks++;
            if (act !== e.exp) begin
               n_errors++;
               $display("FAIL %s: got %02h expected %02h", e.name, act, e.exp);
            end
         end
      end
      if (timer_irq === 1'b1) begin
         irq_cnt++;
         n_checks++;
         if (irq_prev === 1'b1) begin
            n_errors++;
            $display("FAIL irq_width: got high in two consecutive clocks expected single clock");
         end
      end
      irq_prev = timer_irq;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      chk_n  = 0;
      mem_wr = 1'b0;
      repeat (n) step();
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      chk_n    = 0;
      mem_addr = a;
      data_out = d;
      mem_wr   = 1'b1;
      step();
      mem_wr   = 1'b0;
   endtask

   task automatic push(input int k, input logic [7:0] e, input string nm);
      chk_t c;
      c.kind = k;
      c.exp  = e;
      c.name = nm;
      scb.push_back(c);
   endtask

   task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
      mem_wr   = 1'b0;
      mem_addr = a;
      push(0, e, nm);
      chk_n = 1;
      step();
      chk_n = 0;
   endtask

   task automatic rd_irq(input logic [15:0] a, input logic [7:0] e, input logic i,
                         input string nm);
      mem_wr   = 1'b0;
      mem_addr = a;
      push(0, e, {nm, "_data"});
      push(1, {7'd0, i}, {nm, "_irq"});
      chk_n = 2;
      step();
      chk_n = 0;
   endtask

   task automatic cnt_chk(input int e, input string nm);
      mem_wr = 1'b0;
      push(2, e[7:0], nm);
      chk_n = 1;
      step();
      chk_n = 0;
   endtask

   // Expected values that depend on the overflow-delay build option.
`ifdef GB_TIMER_OVF_DELAY_EN
   localparam logic       DLY = 1'b1;
`else
   localparam logic       DLY = 1'b0;
`endif

   initial begin
      reset_n  = 1'b0;
      mem_addr = 16'h0000;
      data_out = 8'h00;
      mem_wr   = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Reset state (cycle n has sys_cnt = n)
      rd(16'hFF04, 8'h00, "rst_div");
      rd(16'hFF05, 8'h00, "rst_tima");
      rd(16'hFF06, 8'h00, "rst_tma");
      rd(16'hFF07, 8'hF8, "rst_tac");
      rd(16'hFF00, 8'hFF, "rst_unmapped");
      rd_irq(16'hFF10, 8'hFF, 1'b0, "rst_other");
      idle(249);
      rd(16'hFF04, 8'h00, "div_c255");
      rd(16'hFF04, 8'h01, "div_c256");

      // Basic count + overflow, tap bit 3, TMA = 00
      wr(16'hFF04, 8'h5A);            // next cycle sys_cnt = 0
      wr(16'hFF06, 8'h00);
      wr(16'hFF05, 8'hFE);
      wr(16'hFF07, 8'h05);
      rd(16'hFF05, 8'hFE, "t2_c3");
      idle(12);
      rd(16'hFF05, 8'hFE, "t2_c16");
      rd(16'hFF05, 8'hFF, "t2_c17");
      idle(14);
      rd(16'hFF05, 8'hFF, "t2_c32");
      rd_irq(16'hFF05, 8'h00, !DLY, "t2_c33");
      rd_irq(16'hFF05, 8'h00, 1'b0, "t2_c34");
      rd_irq(16'hFF05, 8'h00, 1'b0, "t2_c35");
      rd_irq(16'hFF05, 8'h00, 1'b0, "t2_c36");
      rd_irq(16'hFF05, 8'h00, DLY,  "t2_c37");
      rd_irq(16'hFF05, 8'h00, 1'b0, "t2_c38");

      // TIMA write during OVF cancels the reload
      wr(16'hFF07, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF06, 8'h80);
      wr(16'hFF05, 8'hFF);
      wr(16'hFF07, 8'h05);
      rd(16'hFF05, 8'hFF, "t3_c3");
      idle(13);
      rd_irq(16'hFF05, DLY ? 8'h00 : 8'h80, !DLY, "t3_c17");
      wr(16'hFF05, 8'h42);
      rd_irq(16'hFF05, 8'h42, 1'b0, "t3_c19");
      rd_irq(16'hFF05, 8'h42, 1'b0, "t3_c20");
      rd_irq(16'hFF05, 8'h42, 1'b0, "t3_c21");
      rd_irq(16'hFF05, 8'h42, 1'b0, "t3_c22");
      idle(9);
      rd(16'hFF05, 8'h42, "t3_c32");
      rd(16'hFF05, 8'h43, "t3_c33");

      // DIV write while tap bit 9 is high produces exactly one increment
      wr(16'hFF07, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF05, 8'h10);
      wr(16'hFF07, 8'h04);
      idle(598);
      rd(16'hFF05, 8'h10, "t4_c600");
      rd(16'hFF07, 8'hFC, "t4_tac");
      wr(16'hFF04, 8'hFF);
      rd(16'hFF05, 8'h10, "t4_tima_pre");
      rd(16'hFF04, 8'h00, "t4_div_clr");
      rd(16'hFF05, 8'h11, "t4_tima_inc");

      // TMA write in the RELOAD clock
      wr(16'hFF07, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF06, 8'h10);
      wr(16'hFF05, 8'hFF);
      wr(16'hFF07, 8'h05);
      idle(14);
      rd_irq(16'hFF05, DLY ? 8'h00 : 8'h10, !DLY, "t5_c17");
      idle(2);
      rd_irq(16'hFF05, DLY ? 8'h00 : 8'h10, 1'b0, "t5_c20");
      wr(16'hFF06, 8'h77);            // RELOAD clock in the delayed build
      rd_irq(16'hFF05, DLY ? 8'h77 : 8'h10, 1'b0, "t5_c22");
      rd(16'hFF06, 8'h77, "t5_tma");
      cnt_chk(DLY ? 2 : 3, "t5_irq_count");

      // Reset asserted mid-OVF
      wr(16'hFF07, 8'h00);
      wr(16'hFF04, 8'h00);
      wr(16'hFF06, 8'h33);
      wr(16'hFF05, 8'hFF);
      wr(16'hFF07, 8'h05);
      idle(14);
      rd_irq(16'hFF05, DLY ? 8'h00 : 8'h33, !DLY, "t6_c17");
      reset_n = 1'b0;
      rd(16'hFF06, 8'h00, "t6_rst_tma");
      rd(16'hFF07, 8'hF8, "t6_rst_tac");
      rd_irq(16'hFF05, 8'h00, 1'b0, "t6_rst_tima");
      reset_n = 1'b1;
      rd(16'hFF04, 8'h00, "t6_div");
      idle(20);
      cnt_chk(DLY ? 2 : 4, "t6_irq_count");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
